cavlc_dec: RTL and testbench

// - Receive end of the cavlc byte stream. Collects one block of scan-order coefficient bytes,

---
 rtl/cavlc_pkg.sv | 39 +++
 rtl/cavlc_izigzag.sv | 14 +
 rtl/cavlc_dec.sv | 120 ++++++++++++
 tb/tb_cavlc_dec.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared constants, FSM states and the 4x4 zigzag table
// Used by the cavlc decoder (and the matching encoder scan).
package cavlc_pkg;

  localparam int NCOEF = 16;
  localparam int CW    = 8;
  localparam int CNTW  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REORDER = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // scan index -> raster position
  function automatic int zz(input int k);
    case (k)
      0:  zz = 0;
      1:  zz = 1;
      2:  zz = 4;
      3:  zz = 8;
      4:  zz = 5;
      5:  zz = 2;
      6:  zz = 3;
      7:  zz = 6;
      8:  zz = 9;
      9:  zz = 12;
      10: zz = 13;
      11: zz = 10;
      12: zz = 7;
      13: zz = 11;
      14: zz = 14;
      15: zz = 15;
      default: zz = 0;
    endcase
  endfunction

endpackage

// File: rtl/cavlc_izigzag.sv
// cavlc_izigzag: combinational inverse 4x4 zigzag
// i_scan byte k (scan order) -> o_raster byte zz(k) (raster order)
module cavlc_izigzag
  import cavlc_pkg::*;
(
  input  logic [NCOEF*CW-1:0] i_scan,
  output logic [NCOEF*CW-1:0] o_raster
);

  for (genvar k = 0; k < NCOEF; k++) begin : g_perm
    assign o_raster[zz(k)*CW +: CW] = i_scan[k*CW +: CW];
  end

endmodule

// File: rtl/cavlc_dec.sv
// cavlc_dec: collect 16 scan-order bytes, inverse zigzag, emit raster block
// Ports: byte in (in_valid/in_ready/in_last), block out (out_valid/out_ready), err, stall.
module cavlc_dec
  import cavlc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CW-1:0]       data_in,
  input  logic                in_last,
  output logic                in_ready,
  output logic [NCOEF*CW-1:0] block_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err,
  output logic                stall
);

  state_t              r_state;
  state_t              w_nxt;
  logic [CNTW-1:0]     r_cnt;
  logic [CW-1:0]       r_coef [NCOEF];
  logic [NCOEF*CW-1:0] w_scan;
  logic [NCOEF*CW-1:0] w_raster;
  logic [NCOEF*CW-1:0] r_block;
  logic                r_ovalid;
  logic                r_err;
  logic                w_in_rdy;
  logic                w_acc;
  logic                w_full;

  for (genvar k = 0; k < NCOEF; k++) begin : g_pack
    assign w_scan[k*CW +: CW] = r_coef[k];
  end

  cavlc_izigzag u_izz (
    .i_scan   (w_scan),
    .o_raster (w_raster)
  );

  assign w_acc  = in_valid && w_in_rdy;
  assign w_full = (r_cnt == CNTW'(NCOEF-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (w_acc) begin
          if (w_full || in_last) w_nxt = REORDER;
          else                   w_nxt = COLLECT;
        end
      end
      REORDER: w_nxt = OUTPUT;
      OUTPUT:  if (out_ready) w_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_rdy = 1'b0;
    stall    = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_in_rdy = 1'b1;
        stall    = 1'b0;
      end
      COLLECT: w_in_rdy = 1'b1;
      default: ;
    endcase
  end

  // IDLE holds cnt==0, so it shares the COLLECT store path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_block  <= '0;
      r_ovalid <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE, COLLECT: begin
          if (w_acc) begin
            r_coef[r_cnt[3:0]] <= data_in;
            r_cnt <= r_cnt + CNTW'(1);
            if (w_full) begin
              r_err <= !in_last;
            end else if (in_last) begin
              r_err <= 1'b1;
              for (int i = 0; i < NCOEF; i++)
                if (CNTW'(i) > r_cnt) r_coef[i] <= '0;
            end
          end
        end
        REORDER: begin
          r_block  <= w_raster;
          r_ovalid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_ovalid <= 1'b0;
            r_cnt    <= '0;
            for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
          end
        end
      endcase
    end
  end

  assign in_ready  = w_in_rdy;
  assign block_out = r_block;
  assign out_valid = r_ovalid;
  assign err       = r_err;

endmodule

// File: tb/tb_cavlc_dec.sv
// tb_cavlc_dec: scoreboard bench for cavlc_dec
// Directed cases plus random blocks against a zigzag reference model.
module tb_cavlc_dec;

  typedef struct {
    logic [127:0] blk;
    int           err;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   data_in;
  logic         in_last;
  logic         in_ready;
  logic [127:0] block_out;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  logic         stall;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  bit rnd_rdy = 0;
  exp_t sb[$];
  logic [7:0] stim[16];
  logic [127:0] last_exp;
  int ZZ[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  cavlc_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .block_out (block_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic fail_to(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout got 0 expected 1", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got block %0h expected none",
                   block_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_block", block_out, e.blk);
          chk("sb_err", err_cnt, e.err);
          err_cnt = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      fail_to("send_ready");
      return;
    end
    in_valid = 1'b1;
    data_in  = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_block(input int n, input bit last16, input int gmax);
    exp_t e;
    logic [7:0] r[16];
    for (int k = 0; k < 16; k++) r[k] = 8'h00;
    for (int k = 0; k < n; k++) r[ZZ[k]] = stim[k];
    e.blk = '0;
    for (int p = 0; p < 16; p++) e.blk[p*8 +: 8] = r[p];
    e.err = (n < 16 || !last16) ? 1 : 0;
    sb.push_back(e);
    last_exp = e.blk;
    for (int k = 0; k < n; k++) begin
      send(stim[k], (k == n - 1) && (n < 16 || last16));
      if (k < n - 1) repeat ($urandom_range(0, gmax)) tick();
    end
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    if (!out_valid) fail_to("wait_out_valid");
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) fail_to("wait_idle");
  endtask

  task automatic rand_stim();
    for (int k = 0; k < 16; k++) stim[k] = 8'($urandom_range(1, 255));
  endtask

  initial begin
    logic [127:0] m;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_block", block_out, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // ramp
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) stim[k] = 8'(k + 1);
    do_block(16, 1, 0);
    chk("ramp_lat_n1_ov", out_valid, 0);
    chk("ramp_lat_n1_stall", stall, 1);
    chk("ramp_lat_n1_rdy", in_ready, 0);
    tick();
    chk("ramp_lat_n2_ov", out_valid, 1);
    chk("ramp_pos0", block_out[7:0], 8'h01);
    chk("ramp_pos1", block_out[15:8], 8'h02);
    chk("ramp_pos4", block_out[39:32], 8'h03);
    chk("ramp_pos8", block_out[71:64], 8'h04);
    chk("ramp_pos15", block_out[127:120], 8'h10);
    wait_idle();

    // early last
    stim[0] = 8'h7F;
    stim[1] = 8'h80;
    stim[2] = 8'h05;
    do_block(3, 1, 0);
    chk("el_err", err, 1);
    wait_ov();
    chk("el_pos0", block_out[7:0], 8'h7F);
    chk("el_pos1", block_out[15:8], 8'h80);
    chk("el_pos4", block_out[39:32], 8'h05);
    m = '1;
    m[15:0]  = 16'h0000;
    m[39:32] = 8'h00;
    chk("el_zero_fill", block_out & m, 0);
    wait_idle();

    // missing last
    for (int k = 0; k < 16; k++) stim[k] = 8'hAA;
    do_block(16, 0, 0);
    chk("ml_err_hi", err, 1);
    tick();
    chk("ml_err_lo", err, 0);
    wait_ov();
    chk("ml_block", block_out, {16{8'hAA}});
    wait_idle();

    // backpressure, with ignored input while not ready
    out_ready = 1'b0;
    rand_stim();
    do_block(16, 1, 0);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      data_in  = 8'hEE;
      chk("bp_block", block_out, last_exp);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall", stall, 1);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ov", out_valid, 0);
    chk("bp_release_rdy", in_ready, 1);

    // gaps then back-to-back
    rand_stim();
    do_block(16, 1, 2);
    rand_stim();
    do_block(16, 1, 0);
    wait_idle();

    // reset mid-collect
    rand_stim();
    for (int k = 0; k < 7; k++) send(stim[k], 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_err", err, 0);
    chk("mrst_block", block_out, 0);
    chk("mrst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    rand_stim();
    do_block(16, 1, 0);
    wait_idle();

    // random blocks with random consumer stalls
    rnd_rdy = 1;
    for (int b = 0; b < 20; b++) begin
      int n;
      bit l;
      n = $urandom_range(1, 16);
      l = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) stim[k] = 8'($urandom_range(0, 255));
      do_block(n, l, 2);
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    begin
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
        tick();
        t++;
      end
    end
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
